commutator_p2s: RTL and testbench



---
 rtl/commutator_p2s.sv | 121 ++++++++++++
 tb/tb_commutator_p2s.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/commutator_p2s.sv
// commutator_p2s: parallel-to-serial output commutator for the polyphase interpolator.
// Define COMMUTATOR_P2S_DOUBLE_BUFFER_EN to add a one-word shadow register.
module commutator_p2s #(
    parameter int gp_data_width = 8,
    parameter int gp_nr_phases  = 4
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_ena,
    input  logic                                  i_load,
    input  logic [gp_nr_phases*gp_data_width-1:0] i_data,
    output logic [gp_data_width-1:0]              o_data,
    output logic                                  o_valid,
    output logic                                  o_last,
    output logic                                  o_ready,
    output logic                                  o_overrun
);
    localparam int W  = gp_data_width;
    localparam int N  = gp_nr_phases;
    localparam int NW = N * W;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]    state_q;
    logic [NW-1:0] word_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  phase_sel;
    logic [NW-1:0] next_word;
    logic          accept;
    logic          in_last;
    logic          last_cnt;
    logic          start_new;
    logic          advance;
    logic          finish;

    always_comb begin
        phase_sel = '0;
        for (int k = 0; k < N; k++) begin
            if (cnt_q == CW'(k)) begin
                phase_sel = word_q[k*W +: W];
            end
        end
    end

    assign last_cnt = (cnt_q == CW'(N - 1));
    assign in_last  = (state_q == ST_SHIFT) && o_last;
    assign advance  = (state_q == ST_SHIFT) && !o_last;
    assign accept   = i_load && o_ready;

`ifdef COMMUTATOR_P2S_DOUBLE_BUFFER_EN
    logic [NW-1:0] shadow_q;
    logic          shadow_full_q;

    assign o_ready   = !shadow_full_q;
    assign next_word = shadow_full_q ? shadow_q : i_data;
    assign start_new = ((state_q == ST_IDLE) && accept) ||
                       (in_last && (shadow_full_q || accept));
    assign finish    = in_last && !shadow_full_q && !accept;

    // Shadow only fills mid-word; it drains into the buffer on the last phase
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
        end else if (i_ena) begin
            if (advance && accept) begin
                shadow_q      <= i_data;
                shadow_full_q <= 1'b1;
            end else if (in_last && shadow_full_q) begin
                shadow_full_q <= 1'b0;
            end
        end
    end
`else
    assign o_ready   = (state_q == ST_IDLE) || o_last;
    assign next_word = i_data;
    assign start_new = accept;
    assign finish    = in_last && !accept;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            cnt_q     <= '0;
            o_data    <= '0;
            o_valid   <= 1'b0;
            o_last    <= 1'b0;
            o_overrun <= 1'b0;
        end else if (i_ena) begin
            if (i_load && !o_ready) begin
                o_overrun <= 1'b1;
            end
            unique case (1'b1)
                start_new: begin
                    word_q  <= next_word;
                    o_data  <= next_word[W-1:0];
                    o_valid <= 1'b1;
                    o_last  <= (N == 1);
                    cnt_q   <= CW'(1);
                    state_q <= ST_SHIFT;
                end
                advance: begin
                    o_data <= phase_sel;
                    cnt_q  <= cnt_q + 1'b1;
                    o_last <= last_cnt;
                end
                finish: begin
                    o_valid <= 1'b0;
                    o_last  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_commutator_p2s.sv
// tb_commutator_p2s: scoreboard bench for commutator_p2s.
// Sample-count model decides accept/drop; a monitor checks every enabled slot.
module tb_commutator_p2s;
    localparam int W  = 8;
    localparam int N  = 4;
    localparam int NW = N * W;

    typedef struct {
        logic [W-1:0] data;
        bit           last;
    } samp_t;

    typedef struct {
        bit valid;
        bit ovr;
    } slot_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          ena = 1'b0;
    logic          load = 1'b0;
    logic [NW-1:0] din = '0;
    logic [W-1:0]  o_data;
    logic          o_valid;
    logic          o_last;
    logic          o_ready;
    logic          o_overrun;

    logic          ena1 = 1'b0;
    logic          load1 = 1'b0;
    logic [W-1:0]  din1 = '0;
    logic [W-1:0]  d1;
    logic          v1;
    logic          l1;
    logic          r1;
    logic          ov1;

    int n_cmp = 0;
    int n_err = 0;

    samp_t samp_q[$];
    slot_t vq[$];
    int    owed = 0;
    bit    m_ovr = 1'b0;

    always #5 clk = ~clk;

    commutator_p2s #(.gp_data_width(W), .gp_nr_phases(N)) u_dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_ena    (ena),
        .i_load   (load),
        .i_data   (din),
        .o_data   (o_data),
        .o_valid  (o_valid),
        .o_last   (o_last),
        .o_ready  (o_ready),
        .o_overrun(o_overrun)
    );

    commutator_p2s #(.gp_data_width(W), .gp_nr_phases(1)) u_one (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_ena    (ena1),
        .i_load   (load1),
        .i_data   (din1),
        .o_data   (d1),
        .o_valid  (v1),
        .o_last   (l1),
        .o_ready  (r1),
        .o_overrun(ov1)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // A word is accepted if no samples are owed (or, with a shadow, less than a word)
    function automatic bit model_ready();
`ifdef COMMUTATOR_P2S_DOUBLE_BUFFER_EN
        return owed < N;
`else
        return owed == 0;
`endif
    endfunction

    task automatic model_edge(input bit ld, input logic [NW-1:0] d);
        slot_t s;
        if (ld) begin
            if (model_ready()) begin
                owed += N;
                for (int k = 0; k < N; k++) begin
                    samp_q.push_back('{d[k*W +: W], (k == N - 1)});
                end
            end else begin
                m_ovr = 1'b1;
            end
        end
        if (owed > 0) begin
            owed--;
            s.valid = 1'b1;
        end else begin
            s.valid = 1'b0;
        end
        s.ovr = m_ovr;
        vq.push_back(s);
    endtask

    task automatic step(input bit e, input bit ld, input logic [NW-1:0] d);
        @(negedge clk);
        ena  = e;
        load = ld;
        din  = d;
        #1;
        chk("ready", o_ready, model_ready());
        if (e) model_edge(ld, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        ena  = 1'b0;
        load = 1'b0;
        rst  = 1'b1;
        #1;
        chk("async_rst", {o_data, o_valid, o_last, o_overrun}, '0);
        owed  = 0;
        m_ovr = 1'b0;
        samp_q.delete();
        vq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    logic [W-1:0] held = '0;
    logic [W-1:0] p_data = '0;
    logic         p_valid = 1'b0;
    logic         p_last = 1'b0;
    logic         p_ovr = 1'b0;
    samp_t        m_s;
    slot_t        m_v;

    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            chk("rst_out", {o_data, o_valid, o_last, o_overrun}, '0);
            held = '0;
        end else if (ena) begin
            if (vq.size() == 0) begin
                chk("slot_model", 1, 0);
            end else begin
                m_v = vq.pop_front();
                chk("valid", o_valid, m_v.valid);
                chk("overrun", o_overrun, m_v.ovr);
            end
            if (o_valid) begin
                if (samp_q.size() == 0) begin
                    chk("unexpected_sample", 1, 0);
                end else begin
                    m_s = samp_q.pop_front();
                    chk("data", o_data, m_s.data);
                    chk("last", o_last, m_s.last);
                end
                held = o_data;
            end else begin
                chk("idle_hold", o_data, held);
                chk("idle_last", o_last, 0);
            end
        end else begin
            chk("dis_hold", {o_data, o_valid, o_last, o_overrun},
                {p_data, p_valid, p_last, p_ovr});
        end
        p_data  = o_data;
        p_valid = o_valid;
        p_last  = o_last;
        p_ovr   = o_overrun;
    end

    initial begin
        #2 rst = 1'b1;
        #1;
        chk("reset_state", {o_data, o_valid, o_last, o_overrun}, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // single word
        step(1'b1, 1'b1, 32'h44332211);
        idle(6);

        // back-to-back words on the last phase
        step(1'b1, 1'b1, 32'h44332211);
        idle(3);
        step(1'b1, 1'b1, 32'h88776655);
        idle(6);

        // enable toggling with loads while disabled
        step(1'b1, 1'b1, 32'h44332211);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 32'hDEADBEEF);
            step(1'b0, 1'b1, 32'hCAFEF00D);
            step(1'b1, 1'b0, '0);
        end
        idle(3);

        // load while the second phase is shown
        step(1'b1, 1'b1, 32'h44332211);
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, 32'hAABBCCDD);
        idle(10);

        // reset while the third phase is shown
        step(1'b1, 1'b1, 32'h44332211);
        idle(2);
        do_reset();
        idle(5);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                     NW'($urandom()));
            end
        end
        idle(12);
        @(negedge clk);
        ena = 1'b0;
        chk("drain_samples", samp_q.size(), 0);
        chk("drain_slots", vq.size(), 0);

        // single-phase instance
        chk("n1_ready_idle", r1, 1);
        @(negedge clk);
        ena1  = 1'b1;
        load1 = 1'b1;
        din1  = 8'h5A;
        @(posedge clk);
        #1;
        chk("n1_d0", d1, 8'h5A);
        chk("n1_vl0", {v1, l1, r1}, 3'b111);
        @(negedge clk);
        din1 = 8'hA5;
        @(posedge clk);
        #1;
        chk("n1_d1", d1, 8'hA5);
        chk("n1_vl1", {v1, l1, r1}, 3'b111);
        @(negedge clk);
        load1 = 1'b0;
        @(posedge clk);
        #1;
        chk("n1_idle", {d1, v1, l1, r1, ov1}, {8'hA5, 4'b0010});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
